rv_muldiv: RTL and testbench
============================

RV_MULDIV -- requirements
Module: rv_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width in bits (legal: 8..64, power of two).
REQ-002 SHALL have i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have i_reset  input  1  reset; one clock, reset synchronous and active-high.
REQ-004 SHALL have i_valid  input  1  request valid.
REQ-005 SHALL have o_ready  output  1  block can accept a request.
REQ-006 SHALL have i_op  input  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have i_src_a / i_src_b  input  XLEN each  operand A (multiplicand/dividend), operand B (multiplier/divisor).
REQ-008 SHALL have i_flush  input  1  abort any operation in flight.
REQ-009 SHALL have o_valid  output  1  result valid.
REQ-010 SHALL have i_ready  input  1  consumer accepts result.
REQ-011 SHALL have o_result  output  XLEN  result.
REQ-012 SHALL have o_busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX, DONE; o_ready = (state==IDLE), o_valid = (state==DONE).
REQ-014 SHALL accept a request on an edge with i_valid & o_ready & !i_flush, registering op and operands; IDLE->CALC, iteration counter loaded with XLEN.
REQ-015 SHALL in CALC perform one radix-2 step per cycle on operand magnitudes: multiply = shift-add into 2*XLEN product; divide = restoring shift-subtract yielding quotient and remainder.
REQ-016 SHALL leave CALC after exactly XLEN cycles (counter reaches zero) into FIX.
REQ-017 SHALL in FIX apply sign correction (product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign) and select the output half/field; FIX->DONE.
REQ-018 SHALL assert o_valid exactly XLEN+2 cycles after the accept edge for normal operations.
REQ-019 SHALL treat MULHSU as A signed, B unsigned; MULHU/DIVU/REMU as both unsigned; MUL returns low XLEN bits, MULH* return high XLEN bits.
REQ-020 SHALL, for divisor zero, skip CALC (IDLE->FIX): quotient all-ones, remainder = dividend; o_valid 2 cycles after accept.
REQ-021 SHALL, for signed overflow (DIV/REM, A = most negative, B = -1), skip CALC: quotient = A, remainder = 0; o_valid 2 cycles after accept.
REQ-022 SHALL hold o_result stable and o_valid high in DONE until i_ready; DONE & i_ready -> IDLE; no new accept in that same cycle.
REQ-023 SHALL, on i_flush in any state, go to IDLE at the next edge with o_valid low; flush overrides i_valid and i_ready in the same cycle.
REQ-024 SHALL ignore i_op/i_src_* changes after accept.

Reset
REQ-025 SHALL on i_reset (synchronous) enter IDLE: o_valid=0, o_busy=0, o_ready=1, o_result=0, counter=0; reset wins over flush and handshake.
REQ-026 SHALL abandon any in-flight operation on reset mid-CALC/FIX/DONE without producing a result.

Structure
REQ-027 SHALL take op encodings (MD_MUL..MD_REMU) and the FSM state typedef from the shared package rv_pkg, alongside existing ALU control encodings.
REQ-028 SHALL isolate the per-cycle shift-add/shift-subtract datapath in one sub-module rv_md_step; FSM, counter and sign fix-up stay in rv_muldiv.

Verification (XLEN=32)
REQ-029 MUL 7 x 0xFFFFFFFD -> o_result 0xFFFFFFEB, o_valid exactly 34 cycles after accept.
REQ-030 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
REQ-032 DIV 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5, each valid 2 cycles after accept; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-033 Hold i_ready low 10 cycles in DONE -> o_result stable, o_ready low; then i_ready high -> IDLE next edge.
REQ-034 Assert i_flush (then, separately, i_reset) at CALC cycle 10 -> IDLE next edge, no o_valid; next request completes correctly.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared encodings for the ALU and the multiply/divide unit
package rv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic md_is_div(input md_op_e op);
        return op[2];
    endfunction

    function automatic logic md_a_signed(input md_op_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic md_b_signed(input md_op_e op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/rv_md_step.sv
// rtl/rv_md_step.sv - one radix-2 shift-add / restoring shift-subtract step
module rv_md_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem_ext;
    logic [XLEN:0] diff;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    // Divide:   acc = {partial remainder, remaining dividend / quotient bits}, shifted left.
    always_comb begin
        sum      = '0;
        rem_ext  = '0;
        diff     = '0;
        acc_next = acc;
        if (!is_div) begin
            sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
            acc_next = {sum, acc[XLEN-1:1]};
        end else begin
            rem_ext = acc[2*XLEN-1:XLEN-1];
            diff    = rem_ext - {1'b0, operand};
            if (!diff[XLEN])
                acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc_next = {rem_ext[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/rv_muldiv.sv
// rtl/rv_muldiv.sv - iterative RISC-V M-extension multiply/divide unit
module rv_muldiv
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state;
    md_op_e            op_q;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   result_q;

    md_op_e            in_op;
    logic              in_neg_a;
    logic              in_neg_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              div_zero;
    logic              div_ovf;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_result;

    assign in_op    = md_op_e'(i_op);
    assign in_neg_a = md_a_signed(in_op) & i_src_a[XLEN-1];
    assign in_neg_b = md_b_signed(in_op) & i_src_b[XLEN-1];
    assign mag_a    = in_neg_a ? -i_src_a : i_src_a;
    assign mag_b    = in_neg_b ? -i_src_b : i_src_b;
    assign div_zero = md_is_div(in_op) && (i_src_b == '0);
    assign div_ovf  = ((in_op == MD_DIV) || (in_op == MD_REM)) &&
                      (i_src_a == MOST_NEG) && (i_src_b == '1);

    rv_md_step #(.XLEN(XLEN)) u_step (
        .is_div   (md_is_div(op_q)),
        .acc      (acc),
        .operand  (opnd),
        .acc_next (acc_next)
    );

    always_comb begin
        prod_fix   = (neg_a ^ neg_b) ? -acc : acc;
        quo_fix    = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix    = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        fix_result = '0;
        case (op_q)
            MD_MUL:                        fix_result = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  fix_result = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               fix_result = quo_fix;
            default:                       fix_result = rem_fix;
        endcase
    end

    // Divide-by-zero and signed overflow preload acc with the final
    // {remainder, quotient} and clear the sign flags, so FIX passes them through.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= MD_IDLE;
            op_q     <= MD_MUL;
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            result_q <= '0;
        end else if (i_flush) begin
            state <= MD_IDLE;
            count <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (i_valid) begin
                        op_q <= in_op;
                        if (div_zero) begin
                            acc   <= {i_src_a, {XLEN{1'b1}}};
                            neg_a <= 1'b0;
                            neg_b <= 1'b0;
                            state <= MD_FIX;
                        end else if (div_ovf) begin
                            acc   <= {{XLEN{1'b0}}, i_src_a};
                            neg_a <= 1'b0;
                            neg_b <= 1'b0;
                            state <= MD_FIX;
                        end else begin
                            neg_a <= in_neg_a;
                            neg_b <= in_neg_b;
                            count <= CW'(XLEN);
                            state <= MD_CALC;
                            if (md_is_div(in_op)) begin
                                acc  <= {{XLEN{1'b0}}, mag_a};
                                opnd <= mag_b;
                            end else begin
                                acc  <= {{XLEN{1'b0}}, mag_b};
                                opnd <= mag_a;
                            end
                        end
                    end
                end
                MD_CALC: begin
                    acc   <= acc_next;
                    count <= count - 1'b1;
                    if (count == CW'(1))
                        state <= MD_FIX;
                end
                MD_FIX: begin
                    result_q <= fix_result;
                    state    <= MD_DONE;
                end
                MD_DONE: begin
                    if (i_ready)
                        state <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign o_ready  = (state == MD_IDLE);
    assign o_valid  = (state == MD_DONE);
    assign o_busy   = (state != MD_IDLE);
    assign o_result = result_q;

endmodule

// File: tb/tb_rv_muldiv.sv
// tb/tb_rv_muldiv.sv - directed self-checking bench for rv_muldiv
module tb_rv_muldiv;

    localparam int XLEN = 32;
    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b0;
    logic            i_valid = 1'b0;
    logic            o_ready;
    logic [2:0]      i_op = 3'd0;
    logic [XLEN-1:0] i_src_a = '0;
    logic [XLEN-1:0] i_src_b = '0;
    logic            i_flush = 1'b0;
    logic            o_valid;
    logic            i_ready = 1'b0;
    logic [XLEN-1:0] o_result;
    logic            o_busy;

    int total = 0;
    int bad = 0;

    rv_muldiv #(.XLEN(XLEN)) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_src_a  (i_src_a),
        .i_src_b  (i_src_b),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_busy   (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Accepts one request and waits for o_valid; cyc is the cycle index
    // (accept cycle = 0) in which o_valid is first seen, 0 on timeout.
    task automatic start_op(input logic [2:0] op, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b);
        @(negedge i_clk);
        i_op = op; i_src_a = a; i_src_b = b; i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_op = ~op; i_src_a = ~a; i_src_b = 32'h1234_5678;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!o_valid && cyc < 200) begin
            @(posedge i_clk);
            #1;
            cyc++;
        end
        if (!o_valid) cyc = 0;
    endtask

    task automatic consume();
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
    endtask

    task automatic run_check(input string name, input logic [2:0] op,
                             input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                             input logic [XLEN-1:0] exp_res, input int exp_cyc);
        int cyc;
        start_op(op, a, b);
        wait_valid(cyc);
        total++;
        if (o_result !== exp_res) begin
            bad++;
            $display("FAIL %s result: got %h expected %h", name, o_result, exp_res);
        end
        total++;
        if (cyc != exp_cyc) begin
            bad++;
            $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_cyc);
        end
        consume();
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        total++;
        if ({o_ready, o_valid, o_busy} !== 3'b100 || o_result !== '0) begin
            bad++;
            $display("FAIL reset_state: got rdy/vld/busy=%b res=%h expected 100 res=0",
                     {o_ready, o_valid, o_busy}, o_result);
        end
    endtask

    task automatic test_mul();
        run_check("mul", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run_check("mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run_check("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run_check("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        run_check("mulh_neg", OP_MULH, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 34);
    endtask

    task automatic test_div();
        run_check("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_check("rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_check("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
        run_check("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 34);
        run_check("rem_negdiv", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    endtask

    task automatic test_special();
        run_check("div_zero", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        run_check("remu_zero", OP_REMU, 32'd5, 32'd0, 32'd5, 2);
        run_check("rem_zero_neg", OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 2);
        run_check("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_check("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);
    endtask

    task automatic test_hold();
        int cyc;
        int unstable = 0;
        start_op(OP_DIVU, 32'd1000, 32'd9);
        wait_valid(cyc);
        for (int i = 0; i < 10; i++) begin
            @(posedge i_clk);
            #1;
            if (o_result !== 32'd111 || !o_valid || o_ready) unstable++;
        end
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL hold_stable: got %0d unstable cycles expected 0", unstable);
        end
        consume();
        total++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_release: got rdy=%b vld=%b expected rdy=1 vld=0", o_ready, o_valid);
        end
    endtask

    task automatic abort_mid_calc(input string name, input logic use_reset);
        int seen = 0;
        start_op(OP_MUL, 32'd12345, 32'd678);
        for (int i = 1; i < 10; i++) begin
            @(posedge i_clk);
            #1;
        end
        if (use_reset) i_reset = 1'b1; else i_flush = 1'b1;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
        total++;
        if ({o_ready, o_valid, o_busy} !== 3'b100) begin
            bad++;
            $display("FAIL %s_idle: got rdy/vld/busy=%b expected 100", name, {o_ready, o_valid, o_busy});
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge i_clk);
            #1;
            if (o_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL %s_no_valid: got %0d valid cycles expected 0", name, seen);
        end
        run_check({name, "_next"}, OP_MUL, 32'd12345, 32'd678, 32'd8369910, 34);
    endtask

    task automatic test_flush();
        abort_mid_calc("flush", 1'b0);
        abort_mid_calc("reset", 1'b1);
    endtask

    task automatic test_back_to_back();
        run_check("b2b_mulhu", OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1, 34);
        run_check("b2b_divu", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
        run_check("b2b_mul", OP_MUL, 32'h8000_0000, 32'd2, 32'd0, 34);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_hold();
        test_flush();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
